// File: rtl/debug_dump_sequencer_pkg.sv
// debug_dump_sequencer_pkg: shared state, section encodings and word geometry for the dump sequencer
package debug_dump_sequencer_pkg;
  localparam int DEF_BYTE = 8;
  localparam int DEF_DWORD = 32;
  localparam int BYTES_PER_WORD = DEF_DWORD / DEF_BYTE;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, WAIT_TX, NEXT, DONE} state_t;
  typedef enum logic [1:0] {SEC_PC = 2'd0, SEC_REG = 2'd1, SEC_MEM = 2'd2} section_t;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} ser_state_t;
endpackage

// File: rtl/debug_dump_sequencer_word_serializer.sv
// debug_dump_sequencer_word_serializer: loads a word and sends it MSB-first one byte per tx_start/tx_done handshake
module debug_dump_sequencer_word_serializer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int BYTE = DEF_BYTE,
  parameter int DWORD = DEF_DWORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DWORD-1:0] data,
  input  logic             tx_done,
  output logic [BYTE-1:0]  tx_data,
  output logic             tx_start,
  output logic             word_done
);
  localparam int BPW = DWORD / BYTE;
  localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
  ser_state_t st, st_n;
  logic [DWORD-1:0] shift;
  logic [CW-1:0] cnt;
  logic last, ack;
  always_comb begin
    last = cnt == CW'(BPW - 1);
    ack = st == S_WAIT && tx_done;
    st_n = load ? S_SEND : st == S_SEND ? S_WAIT : ack ? (last ? S_IDLE : S_SEND) : st;
  end
  assign tx_start = st == S_SEND;
  assign tx_data = shift[DWORD-1 -: BYTE];
  assign word_done = ack && last;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      shift <= '0;
      cnt <= '0;
    end else begin
      st <= st_n;
      if (load) begin
        shift <= data;
        cnt <= '0;
      end else if (ack && !last) begin
        shift <= shift << BYTE;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: walks PC, register bank and memory window, streaming each word as bytes to the debug UART
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int BYTE = DEF_BYTE,
  parameter int DWORD = DEF_DWORD,
  parameter int RB_ADDR = 5,
  parameter int MEM_ADDR = 5,
  parameter int RB_COUNT = 32,
  parameter int MEM_COUNT = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_tx_done,
  input  logic [DWORD-1:0]    i_pc_value,
  input  logic [DWORD-1:0]    i_bank_reg_data,
  input  logic [DWORD-1:0]    i_mem_data,
  output logic [RB_ADDR-1:0]  o_rb_addr,
  output logic                o_rb_read_enable,
  output logic [MEM_ADDR-1:0] o_mem_data_addr,
  output logic                o_mem_data_read_enable,
  output logic [BYTE-1:0]     o_tx_data,
  output logic                o_tx_start,
  output logic                o_busy,
  output logic                o_done
);
  localparam int MAXC = RB_COUNT > MEM_COUNT ? RB_COUNT : MEM_COUNT;
  localparam int WW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [WW-1:0] RB_LAST = WW'(RB_COUNT - 1);
  localparam logic [WW-1:0] MEM_LAST = WW'(MEM_COUNT - 1);
  state_t state, state_n;
  section_t sec, sec_n;
  logic [WW-1:0] word, word_n;
  logic [RB_ADDR-1:0] rb_hold;
  logic [MEM_ADDR-1:0] mem_hold;
  logic [DWORD-1:0] src;
  logic word_done, last;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      sec <= SEC_PC;
      word <= '0;
      rb_hold <= '0;
      mem_hold <= '0;
    end else begin
      state <= state_n;
      sec <= sec_n;
      word <= word_n;
      rb_hold <= o_rb_addr;
      mem_hold <= o_mem_data_addr;
    end
  end
  always_comb begin
    state_n = state;
    sec_n = sec;
    word_n = word;
    last = sec == SEC_PC || (sec == SEC_REG && word == RB_LAST) || (sec == SEC_MEM && word == MEM_LAST);
    case (state)
      IDLE: if (i_start) begin
        state_n = READ;
        sec_n = SEC_PC;
        word_n = '0;
      end
      READ: state_n = CAPTURE;
      CAPTURE: state_n = SEND;
      SEND: state_n = WAIT_TX;
      WAIT_TX: if (word_done) state_n = NEXT;
      NEXT: begin
        word_n = last ? '0 : word + 1'b1;
        state_n = READ;
        if (last) begin
          if (sec == SEC_PC && RB_COUNT > 0) sec_n = SEC_REG;
          else if (sec != SEC_MEM && MEM_COUNT > 0) sec_n = SEC_MEM;
          else state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign o_rb_read_enable = state == READ && sec == SEC_REG;
  assign o_mem_data_read_enable = state == READ && sec == SEC_MEM;
  assign o_rb_addr = o_rb_read_enable ? RB_ADDR'(word) : rb_hold;
  assign o_mem_data_addr = o_mem_data_read_enable ? MEM_ADDR'(word) : mem_hold;
  assign o_busy = state != IDLE && state != DONE;
  assign o_done = state == DONE;
  assign src = sec == SEC_PC ? i_pc_value : sec == SEC_REG ? i_bank_reg_data : i_mem_data;
  debug_dump_sequencer_word_serializer #(.BYTE(BYTE), .DWORD(DWORD)) u_ser (
    .clk(i_clock),
    .rst(i_reset),
    .load(state == CAPTURE),
    .data(src),
    .tx_done(i_tx_done),
    .tx_data(o_tx_data),
    .tx_start(o_tx_start),
    .word_done(word_done)
  );
endmodule

// File: tb/tb_debug_dump_sequencer.sv
// tb_debug_dump_sequencer: scoreboard bench for the full dump and a reduced register-only dump
module tb_debug_dump_sequencer;
  logic clk = 0, rst = 1, start = 0, start_b = 0, tx_done = 0, tx_done_b = 0;
  logic [31:0] pc = 32'h1234_5678;
  logic [31:0] rb_data = 0, mem_data = 0, rb_data_b = 0, mem_data_b = 0;
  logic [4:0] rb_addr, mem_addr, rb_addr_b, mem_addr_b, rb_ad, mem_ad, rb_ad_b;
  logic rb_en, mem_en, rb_en_b, mem_en_b, rb_d = 0, mem_d = 0, rb_d_b = 0;
  logic [7:0] tx_data, tx_data_b;
  logic tx_start, tx_start_b, busy, busy_b, done, done_b;
  logic [7:0] exp_q[$], exp_qb[$];
  int checks = 0, errors = 0;
  int tx_cnt = 0, run_bytes = 0, rb_next = 0, mem_next = 0, rb_tot = 0, mem_tot = 0, done_cnt = 0;
  int tx_cnt_b = 0, rb_tot_b = 0, mem_tot_b = 0, done_cnt_b = 0;
  int pend = 0, pend_b = 0;
  bit spur = 0;
  always #5 clk = ~clk;
  debug_dump_sequencer dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_tx_done(tx_done),
    .i_pc_value(pc), .i_bank_reg_data(rb_data), .i_mem_data(mem_data),
    .o_rb_addr(rb_addr), .o_rb_read_enable(rb_en),
    .o_mem_data_addr(mem_addr), .o_mem_data_read_enable(mem_en),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy), .o_done(done)
  );
  debug_dump_sequencer #(.RB_COUNT(4), .MEM_COUNT(0)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(start_b), .i_tx_done(tx_done_b),
    .i_pc_value(pc), .i_bank_reg_data(rb_data_b), .i_mem_data(mem_data_b),
    .o_rb_addr(rb_addr_b), .o_rb_read_enable(rb_en_b),
    .o_mem_data_addr(mem_addr_b), .o_mem_data_read_enable(mem_en_b),
    .o_tx_data(tx_data_b), .o_tx_start(tx_start_b), .o_busy(busy_b), .o_done(done_b)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_dump(input bit b, input int nrb, input int nmem);
    logic [31:0] w;
    for (int i = 0; i < 1 + nrb + nmem; i++) begin
      w = i == 0 ? pc : i <= nrb ? 32'(i - 1) : 32'hA000_0000 + 32'(i - 1 - nrb);
      for (int j = 3; j >= 0; j--)
        if (b) exp_qb.push_back(w[j*8 +: 8]);
        else exp_q.push_back(w[j*8 +: 8]);
    end
  endtask
  initial forever begin
    @(posedge clk); #1;
    rb_data = rb_d ? {27'b0, rb_ad} : 32'hDEAD_BEEF;
    mem_data = mem_d ? 32'hA000_0000 + {27'b0, mem_ad} : 32'hDEAD_BEEF;
    rb_data_b = rb_d_b ? {27'b0, rb_ad_b} : 32'hDEAD_BEEF;
    rb_d = rb_en;
    rb_ad = rb_addr;
    mem_d = mem_en;
    mem_ad = mem_addr;
    rb_d_b = rb_en_b;
    rb_ad_b = rb_addr_b;
  end
  initial forever begin
    @(posedge clk); #1;
    tx_done = 0;
    tx_done_b = 0;
    if (rst) begin
      pend = 0;
      pend_b = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) tx_done = 1;
      end
      if (tx_start) begin
        pend = 3;
        if (spur) tx_done = 1;
      end
      if (pend_b > 0) begin
        pend_b--;
        if (pend_b == 0) tx_done_b = 1;
      end
      if (tx_start_b) pend_b = $urandom_range(20, 1);
    end
  end
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      tx_cnt++;
      run_bytes++;
      if (exp_q.size() > 0) check("tx_byte", tx_data, exp_q.pop_front());
      else check("tx_unexpected", tx_start, 0);
    end
    if (rb_en || mem_en) begin
      check("strobe_exclusive", rb_en && mem_en, 0);
      check("strobe_after_pc", run_bytes >= 4, 1);
    end
    if (rb_en) begin
      check("rb_addr", rb_addr, rb_next);
      rb_next++;
      rb_tot++;
    end
    if (mem_en) begin
      check("mem_addr", mem_addr, mem_next);
      mem_next++;
      mem_tot++;
    end
    if (done) done_cnt++;
    if (done || rst) begin
      run_bytes = 0;
      rb_next = 0;
      mem_next = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (tx_start_b) begin
      tx_cnt_b++;
      if (exp_qb.size() > 0) check("b_tx_byte", tx_data_b, exp_qb.pop_front());
      else check("b_tx_unexpected", tx_start_b, 0);
    end
    if (rb_en_b) begin
      check("b_rb_addr", rb_addr_b, rb_tot_b);
      rb_tot_b++;
    end
    if (mem_en_b) mem_tot_b++;
    if (done_b) done_cnt_b++;
  end
  task automatic full_dump(input bit mid);
    int base, dbase, rbase, mbase;
    base = tx_cnt;
    dbase = done_cnt;
    rbase = rb_tot;
    mbase = mem_tot;
    push_dump(0, 32, 32);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    check("busy_after_start", busy, 1);
    if (mid) begin
      for (int i = 0; i < 5000 && tx_cnt - base < 50; i++) @(posedge clk);
      #1 start = 1;
      @(posedge clk); #1 start = 0;
    end
    for (int i = 0; i < 20000 && done_cnt == dbase; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("done_pulses", done_cnt - dbase, 1);
    check("tx_count", tx_cnt - base, 260);
    check("queue_left", exp_q.size(), 0);
    check("rb_strobes", rb_tot - rbase, 32);
    check("mem_strobes", mem_tot - mbase, 32);
    check("busy_end", busy, 0);
  endtask
  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_tx_start", tx_start, 0);
    check("idle_tx_data", tx_data, 0);
    check("idle_rb_en", rb_en, 0);
    check("idle_mem_en", mem_en, 0);
    check("idle_rb_addr", rb_addr, 0);
    check("idle_mem_addr", mem_addr, 0);
    check("idle_tx_count", tx_cnt, 0);
    full_dump(0);
    spur = 1;
    full_dump(1);
    spur = 0;
    base = tx_cnt;
    push_dump(0, 32, 32);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (tx_start && tx_cnt - base == 99) break;
    end
    check("tx_start_at_byte_100", tx_start, 1);
    rst = 1;
    @(posedge clk); #1;
    check("reset_tx_start", tx_start, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    full_dump(0);
    base = done_cnt_b;
    push_dump(1, 4, 0);
    @(posedge clk); #1 start_b = 1;
    @(posedge clk); #1 start_b = 0;
    for (int i = 0; i < 5000 && done_cnt_b == base; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("b_done_pulses", done_cnt_b - base, 1);
    check("b_tx_count", tx_cnt_b, 20);
    check("b_queue_left", exp_qb.size(), 0);
    check("b_rb_strobes", rb_tot_b, 4);
    check("b_mem_strobes", mem_tot_b, 0);
    check("b_busy_end", busy_b, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
